stream_demux_1ton: RTL and testbench
====================================

Name: stream_demux_1ton

Overview:
- Registered, parametrised 1-to-N stream demultiplexer. One input stream is steered to one or more of N output channels under valid/ready handshakes.
- Each channel has its own one-entry output register, so a stalled channel never corrupts the others.
- Three steering modes: addressed, broadcast and round-robin.
- Sits between a single producer and N consumer blocks in the datapath. It is the clocked, flow-controlled generalisation of the team's combinational 1-to-4 demux.

Parameters:
- WIDTH, 8, payload width in bits.
- N, 4, number of output channels; legal range 2..16.
- SEL_W, 2, width of in_sel; must satisfy 2**SEL_W >= N.
- CNT_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- mode  in  2  00 addressed, 01 broadcast, 10 round-robin, 11 reserved (behaves as addressed).
- in_data  in  WIDTH  input payload.
- in_valid  in  1  input payload valid.
- in_sel  in  SEL_W  target channel in addressed mode; ignored in other modes.
- in_ready  out  1  block can accept the input this cycle.
- out_data  out  N*WIDTH  channel i payload at bits [i*WIDTH +: WIDTH].
- out_valid  out  N  per-channel valid.
- out_ready  in  N  per-channel consumer ready.
- rr_ptr  out  SEL_W  next round-robin target.
- drop_cnt  out  CNT_W  count of dropped inputs (in_sel >= N).

Behaviour:
- One clock, synchronous active-low reset (rst_n sampled on rising clk).
- Reset values: out_valid=0, out_data=0, rr_ptr=0, drop_cnt=0.
- Reset mid-operation discards all held payloads. No transfer completes on a reset cycle.
- Channel slot i is free when out_valid[i]==0 or out_ready[i]==1. This gives full throughput: a channel can be drained and refilled in the same cycle.
- Input transfer occurs when in_valid && in_ready at a rising edge. It is registered into the target slot(s), and out_valid is asserted the next cycle (latency 1).
- Addressed mode:
  - Target = in_sel. in_ready = free[in_sel].
  - If in_sel >= N: in_ready=1, payload dropped, no out_valid change, drop_cnt increments.
  - drop_cnt saturates at 2**CNT_W-1.
- Broadcast mode:
  - in_ready = AND of free[0..N-1].
  - On transfer, all N slots load in_data and all out_valid bits set. Atomic: never a partial broadcast.
- Round-robin mode:
  - Target = rr_ptr. in_ready = free[rr_ptr].
  - On transfer, rr_ptr advances by one and wraps from N-1 to 0.
  - rr_ptr holds in other modes and on non-transfer cycles.
  - in_sel is ignored; no drops occur.
- in_ready is combinational from mode, in_sel, rr_ptr, out_valid and out_ready. It must not depend on in_valid.
- Output side, per channel:
  - When out_valid[i] && out_ready[i] and no new load, out_valid[i] clears next cycle.
  - A simultaneous drain and load keeps out_valid[i]=1 with the new data.
  - out_data[i] is stable while out_valid[i]==1 and out_ready[i]==0.
- Stable channels: out_data of untargeted channels is unchanged.
- Mode changes take effect on the cycle they are presented. Payloads already held are unaffected.

Test Plan:
- Reset, addressed mode, out_ready=all 1. Send 0xA0,0xA1,0xA2,0xA3 with in_sel=0,1,2,3 on consecutive cycles. Required: each appears on its channel exactly one cycle later, in_ready stays 1, and no other channel's out_valid asserts.
- Addressed backpressure:
  - Hold out_ready[2]=0 and send two payloads 0x11, 0x22 with in_sel=2.
  - Required: first is held with out_valid[2]=1; in_ready=0 on the second; 0x11 is stable.
  - Raise out_ready[2]: 0x11 drains and 0x22 loads the same cycle.
- Broadcast with out_ready=4'b1011 and all slots full. Required: in_ready=0 and no channel updates. With all slots free, send 0x5A: all four out_valid=1 and every out_data=0x5A the next cycle.
- Round-robin: send 6 payloads 0x00..0x05 with all ready. Required: channels 0,1,2,3,0,1 in order and rr_ptr ends at 2. Stall channel 2: in_ready=0 and rr_ptr holds at 2.
- Drop/saturation (N=3, SEL_W=2): send 300 payloads with in_sel=3. Required: in_ready=1 every cycle, no out_valid activity, drop_cnt=255.
- Reset mid-operation: assert rst_n=0 for one cycle while slots are full and in_valid=1. Required: out_valid=0, rr_ptr=0 and drop_cnt=0 the next cycle, with no payload transferred.

Source files
------------

// File: rtl/stream_demux_1ton_if.sv
// Stream bundle between one producer, the 1-to-N demux and its N consumers.
// The master side is the producer/consumer environment; the slave side is the demux.
interface stream_demux_1ton_if #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SEL_W = 2
);
  logic [WIDTH-1:0]   in_data;
  logic               in_valid;
  logic [SEL_W-1:0]   in_sel;
  logic               in_ready;
  logic [N*WIDTH-1:0] out_data;
  logic [N-1:0]       out_valid;
  logic [N-1:0]       out_ready;

  modport master (
    output in_data, in_valid, in_sel, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_sel, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/stream_demux_1ton.sv
// Registered 1-to-N stream demultiplexer with addressed, broadcast and
// round-robin steering. Every channel owns a one-entry output register, so a
// stalled consumer only blocks traffic aimed at its own channel.
module stream_demux_1ton #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SEL_W = 2,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           mode,
  stream_demux_1ton_if.slave   bus,
  output logic [SEL_W-1:0]     rr_ptr,
  output logic [CNT_W-1:0]     drop_cnt
);

  typedef enum logic [1:0] {
    MODE_ADDR  = 2'b00,
    MODE_BCAST = 2'b01,
    MODE_RR    = 2'b10,
    MODE_RSVD  = 2'b11
  } modeT;

  localparam logic [SEL_W:0]   NUM_CH   = (SEL_W+1)'(N);
  localparam logic [SEL_W-1:0] LAST_PTR = SEL_W'(N-1);

  logic [WIDTH-1:0] r_outData [N];
  logic [N-1:0]     r_outValid;
  logic [SEL_W-1:0] r_rrPtr;
  logic [CNT_W-1:0] r_dropCnt;

  modeT             w_mode;
  logic [N-1:0]     w_free;
  logic [N-1:0]     w_addrHot;
  logic [N-1:0]     w_rrHot;
  logic             w_addrFree;
  logic             w_rrFree;
  logic             w_selInRange;
  logic             w_inReady;
  logic [N-1:0]     w_load;
  logic             w_drop;
  logic             w_advance;

  assign w_mode       = modeT'(mode);
  assign w_free       = ~r_outValid | bus.out_ready;
  assign w_selInRange = ({1'b0, bus.in_sel} < NUM_CH);

  // Decode the addressed and round-robin targets into one-hot masks and pick
  // out the free flag of each target without indexing past channel N-1.
  always_comb begin
    w_addrHot  = '0;
    w_rrHot    = '0;
    w_addrFree = 1'b0;
    w_rrFree   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (SEL_W'(i) == bus.in_sel) begin
        w_addrHot[i] = 1'b1;
        w_addrFree   = w_free[i];
      end
      if (SEL_W'(i) == r_rrPtr) begin
        w_rrHot[i] = 1'b1;
        w_rrFree   = w_free[i];
      end
    end
  end

  // Steering: in_ready comes only from mode, target and slot occupancy, never
  // from in_valid; the load mask and drop/advance strobes need a real transfer.
  always_comb begin
    w_inReady = 1'b0;
    w_load    = '0;
    w_drop    = 1'b0;
    w_advance = 1'b0;
    case (w_mode)
      MODE_BCAST: begin
        w_inReady = &w_free;
        if (bus.in_valid && w_inReady) begin
          w_load = '1;
        end
      end
      MODE_RR: begin
        w_inReady = w_rrFree;
        if (bus.in_valid && w_inReady) begin
          w_load    = w_rrHot;
          w_advance = 1'b1;
        end
      end
      default: begin
        if (!w_selInRange) begin
          w_inReady = 1'b1;
          w_drop    = bus.in_valid;
        end else begin
          w_inReady = w_addrFree;
          if (bus.in_valid && w_inReady) begin
            w_load = w_addrHot;
          end
        end
      end
    endcase
  end

  // Per-channel output register: a load wins over a drain, so a slot can be
  // emptied and refilled on the same edge; otherwise an accepted beat empties it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_outValid <= '0;
      for (int i = 0; i < N; i++) begin
        r_outData[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        if (w_load[i]) begin
          r_outData[i]  <= bus.in_data;
          r_outValid[i] <= 1'b1;
        end else if (bus.out_ready[i]) begin
          r_outValid[i] <= 1'b0;
        end
      end
    end
  end

  // Round-robin pointer moves only on a round-robin transfer and wraps at N-1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rrPtr <= '0;
    end else if (w_advance) begin
      if (r_rrPtr == LAST_PTR) begin
        r_rrPtr <= '0;
      end else begin
        r_rrPtr <= r_rrPtr + 1'b1;
      end
    end
  end

  // Count inputs addressed to a nonexistent channel, sticking at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dropCnt <= '0;
    end else if (w_drop && (r_dropCnt != '1)) begin
      r_dropCnt <= r_dropCnt + 1'b1;
    end
  end

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign bus.out_data[g*WIDTH +: WIDTH] = r_outData[g];
  end

  assign bus.out_valid = r_outValid;
  assign bus.in_ready  = w_inReady;
  assign rr_ptr        = r_rrPtr;
  assign drop_cnt      = r_dropCnt;

endmodule

// File: tb/tb_stream_demux_1ton.sv
// Directed bench for the 1-to-N stream demux: a vector table on a 4-channel
// instance plus hand-written sequences for drop saturation on a 3-channel
// instance, non-power-of-two round-robin wrap and reset during traffic.
module tb_stream_demux_1ton;

  logic       clk;
  logic       rst_n;
  logic [1:0] modeA;
  logic [1:0] modeB;
  logic [1:0] rrPtrA;
  logic [1:0] rrPtrB;
  logic [7:0] dropCntA;
  logic [7:0] dropCntB;

  int errorCount;
  int checkCount;

  stream_demux_1ton_if #(.WIDTH(8), .N(4), .SEL_W(2)) busA ();
  stream_demux_1ton_if #(.WIDTH(8), .N(3), .SEL_W(2)) busB ();

  stream_demux_1ton #(.WIDTH(8), .N(4), .SEL_W(2), .CNT_W(8)) dutA (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (modeA),
    .bus      (busA.slave),
    .rr_ptr   (rrPtrA),
    .drop_cnt (dropCntA)
  );

  stream_demux_1ton #(.WIDTH(8), .N(3), .SEL_W(2), .CNT_W(8)) dutB (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode     (modeB),
    .bus      (busB.slave),
    .rr_ptr   (rrPtrB),
    .drop_cnt (dropCntB)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  data;
    logic        valid;
    logic [1:0]  sel;
    logic [3:0]  ordy;
    logic        expRdy;
    logic [3:0]  expValid;
    logic [31:0] expData;
    logic [1:0]  expRr;
  } vecT;

  vecT vecs [26];

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vecT v, input int idx);
    @(negedge clk);
    modeA            = v.mode;
    busA.in_data     = v.data;
    busA.in_valid    = v.valid;
    busA.in_sel      = v.sel;
    busA.out_ready   = v.ordy;
    #1;
    checkOutput($sformatf("v%0d in_ready", idx), 32'(busA.in_ready), 32'(v.expRdy));
    @(posedge clk);
    #1;
    checkOutput($sformatf("v%0d out_valid", idx), 32'(busA.out_valid), 32'(v.expValid));
    checkOutput($sformatf("v%0d out_data", idx), busA.out_data, v.expData);
    checkOutput($sformatf("v%0d rr_ptr", idx), 32'(rrPtrA), 32'(v.expRr));
    checkOutput($sformatf("v%0d drop_cnt", idx), 32'(dropCntA), 32'd0);
  endtask

  initial begin
    int expDrop;
    errorCount = 0;
    checkCount = 0;

    //           mode   data   vld   sel   ordy  rdy   valid    data          rr
    // addressed sweep, all consumers ready
    vecs[0]  = '{2'd0, 8'hA0, 1'b1, 2'd0, 4'hF, 1'b1, 4'b0001, 32'h000000A0, 2'd0};
    vecs[1]  = '{2'd0, 8'hA1, 1'b1, 2'd1, 4'hF, 1'b1, 4'b0010, 32'h0000A1A0, 2'd0};
    vecs[2]  = '{2'd0, 8'hA2, 1'b1, 2'd2, 4'hF, 1'b1, 4'b0100, 32'h00A2A1A0, 2'd0};
    vecs[3]  = '{2'd0, 8'hA3, 1'b1, 2'd3, 4'hF, 1'b1, 4'b1000, 32'hA3A2A1A0, 2'd0};
    vecs[4]  = '{2'd0, 8'h00, 1'b0, 2'd0, 4'hF, 1'b1, 4'b0000, 32'hA3A2A1A0, 2'd0};
    // addressed backpressure on channel 2
    vecs[5]  = '{2'd0, 8'h11, 1'b1, 2'd2, 4'hB, 1'b1, 4'b0100, 32'hA311A1A0, 2'd0};
    vecs[6]  = '{2'd0, 8'h22, 1'b1, 2'd2, 4'hB, 1'b0, 4'b0100, 32'hA311A1A0, 2'd0};
    vecs[7]  = '{2'd0, 8'h22, 1'b1, 2'd2, 4'hF, 1'b1, 4'b0100, 32'hA322A1A0, 2'd0};
    vecs[8]  = '{2'd0, 8'h00, 1'b0, 2'd2, 4'hF, 1'b1, 4'b0000, 32'hA322A1A0, 2'd0};
    // fill every slot with consumers stalled
    vecs[9]  = '{2'd0, 8'hB0, 1'b1, 2'd0, 4'h0, 1'b1, 4'b0001, 32'hA322A1B0, 2'd0};
    vecs[10] = '{2'd0, 8'hB1, 1'b1, 2'd1, 4'h0, 1'b1, 4'b0011, 32'hA322B1B0, 2'd0};
    vecs[11] = '{2'd0, 8'hB2, 1'b1, 2'd2, 4'h0, 1'b1, 4'b0111, 32'hA3B2B1B0, 2'd0};
    vecs[12] = '{2'd0, 8'hB3, 1'b1, 2'd3, 4'h0, 1'b1, 4'b1111, 32'hB3B2B1B0, 2'd0};
    // broadcast blocked by channel 2, then broadcast into all-free slots
    vecs[13] = '{2'd1, 8'h5A, 1'b1, 2'd0, 4'hB, 1'b0, 4'b0100, 32'hB3B2B1B0, 2'd0};
    vecs[14] = '{2'd1, 8'h5A, 1'b1, 2'd0, 4'hF, 1'b1, 4'b1111, 32'h5A5A5A5A, 2'd0};
    vecs[15] = '{2'd0, 8'h00, 1'b0, 2'd0, 4'hF, 1'b1, 4'b0000, 32'h5A5A5A5A, 2'd0};
    // round-robin over six payloads
    vecs[16] = '{2'd2, 8'h00, 1'b1, 2'd3, 4'hF, 1'b1, 4'b0001, 32'h5A5A5A00, 2'd1};
    vecs[17] = '{2'd2, 8'h01, 1'b1, 2'd3, 4'hF, 1'b1, 4'b0010, 32'h5A5A0100, 2'd2};
    vecs[18] = '{2'd2, 8'h02, 1'b1, 2'd0, 4'hF, 1'b1, 4'b0100, 32'h5A020100, 2'd3};
    vecs[19] = '{2'd2, 8'h03, 1'b1, 2'd0, 4'hF, 1'b1, 4'b1000, 32'h03020100, 2'd0};
    vecs[20] = '{2'd2, 8'h04, 1'b1, 2'd1, 4'hF, 1'b1, 4'b0001, 32'h03020104, 2'd1};
    vecs[21] = '{2'd2, 8'h05, 1'b1, 2'd1, 4'hF, 1'b1, 4'b0010, 32'h03020504, 2'd2};
    // occupy channel 2 via addressed mode, then stall round-robin on it
    vecs[22] = '{2'd0, 8'h77, 1'b1, 2'd2, 4'hB, 1'b1, 4'b0100, 32'h03770504, 2'd2};
    vecs[23] = '{2'd2, 8'h88, 1'b1, 2'd0, 4'hB, 1'b0, 4'b0100, 32'h03770504, 2'd2};
    vecs[24] = '{2'd2, 8'h88, 1'b1, 2'd0, 4'hF, 1'b1, 4'b0100, 32'h03880504, 2'd3};
    // reserved mode steers like addressed mode
    vecs[25] = '{2'd3, 8'h99, 1'b1, 2'd1, 4'hF, 1'b1, 4'b0010, 32'h03889904, 2'd3};

    modeA          = 2'd0;
    modeB          = 2'd0;
    busA.in_data   = '0;
    busA.in_valid  = 1'b0;
    busA.in_sel    = '0;
    busA.out_ready = '0;
    busB.in_data   = '0;
    busB.in_valid  = 1'b0;
    busB.in_sel    = '0;
    busB.out_ready = '0;
    rst_n          = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset out_valid", 32'(busA.out_valid), 32'd0);
    checkOutput("reset out_data", busA.out_data, 32'd0);
    checkOutput("reset rr_ptr", 32'(rrPtrA), 32'd0);
    checkOutput("reset drop_cnt", 32'(dropCntA), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 26; i++) begin
      applyStimulus(vecs[i], i);
    end

    @(negedge clk);
    busA.in_valid  = 1'b0;
    busA.out_ready = 4'hF;

    // Out-of-range selects on the 3-channel instance: always accepted, never
    // forwarded, counted up to the saturation point.
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      modeB          = 2'd0;
      busB.in_data   = 8'(k);
      busB.in_valid  = 1'b1;
      busB.in_sel    = 2'd3;
      busB.out_ready = 3'b111;
      #1;
      checkOutput($sformatf("drop%0d in_ready", k), 32'(busB.in_ready), 32'd1);
      @(posedge clk);
      #1;
      expDrop = (k > 255) ? 255 : k;
      checkOutput($sformatf("drop%0d out_valid", k), 32'(busB.out_valid), 32'd0);
      checkOutput($sformatf("drop%0d drop_cnt", k), 32'(dropCntB), 32'(expDrop));
    end

    // Round-robin on three channels must wrap from 2 back to 0.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      modeB          = 2'd2;
      busB.in_data   = 8'(8'hC0 + k);
      busB.in_valid  = 1'b1;
      busB.in_sel    = 2'd3;
      busB.out_ready = 3'b111;
      @(posedge clk);
      #1;
      checkOutput($sformatf("rrwrap%0d rr_ptr", k), 32'(rrPtrB), 32'((k + 1) % 3));
      checkOutput($sformatf("rrwrap%0d out_valid", k), 32'(busB.out_valid), 32'(1 << k));
      checkOutput($sformatf("rrwrap%0d drop_cnt", k), 32'(dropCntB), 32'd255);
    end

    // Fill all four slots, then reset while stalled with a beat offered.
    @(negedge clk);
    modeA          = 2'd1;
    busA.in_data   = 8'hC3;
    busA.in_valid  = 1'b1;
    busA.out_ready = 4'hF;
    @(posedge clk);
    #1;
    checkOutput("prereset out_valid", 32'(busA.out_valid), 32'hF);
    checkOutput("prereset out_data", busA.out_data, 32'hC3C3C3C3);
    checkOutput("prereset rr_ptr", 32'(rrPtrA), 32'd3);

    @(negedge clk);
    modeA          = 2'd2;
    busA.in_data   = 8'hD4;
    busA.in_valid  = 1'b1;
    busA.out_ready = 4'h0;
    busB.in_valid  = 1'b1;
    busB.out_ready = 3'b000;
    rst_n          = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("midreset out_valid", 32'(busA.out_valid), 32'd0);
    checkOutput("midreset out_data", busA.out_data, 32'd0);
    checkOutput("midreset rr_ptr", 32'(rrPtrA), 32'd0);
    checkOutput("midreset drop_cnt", 32'(dropCntA), 32'd0);
    checkOutput("midreset B drop_cnt", 32'(dropCntB), 32'd0);
    checkOutput("midreset B out_valid", 32'(busB.out_valid), 32'd0);

    @(negedge clk);
    rst_n         = 1'b1;
    busA.in_valid = 1'b0;
    busB.in_valid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("postreset out_valid", 32'(busA.out_valid), 32'd0);
    checkOutput("postreset rr_ptr", 32'(rrPtrA), 32'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
